// File: rtl/branch_pkg.sv
// branch_pkg: shared types and helpers for the branch target buffer.
//   XLEN         - architectural PC width.
//   CTR_W_MAX    - widest direction counter an entry can store.
//   SNT/WNT/WT/ST- 2-bit direction counter encodings.
//   btb_entry_t  - one table entry (valid, tag, target, ctr).
//   pc_idx/pc_tag- split a PC into table index and tag for a given IDX_W.
// The tag field is XLEN wide and ctr is CTR_W_MAX wide, so the struct can
// serve any table geometry. Unused upper bits are always written as zero.
package branch_pkg;

    localparam int XLEN      = 32;
    localparam int CTR_W_MAX = 8;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      tag;
        logic [XLEN-1:0]      target;
        logic [CTR_W_MAX-1:0] ctr;
    } btb_entry_t;

    // Index is pc[idx_w+1:2], returned zero-extended.
    function automatic logic [XLEN-1:0] pc_idx(input logic [XLEN-1:0] pc,
                                               input int idx_w);
        return (pc >> 2) & ((XLEN'(1) << idx_w) - XLEN'(1));
    endfunction

    // Tag is pc[31:idx_w+2], returned zero-extended.
    function automatic logic [XLEN-1:0] pc_tag(input logic [XLEN-1:0] pc,
                                               input int idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/branch_btb_sat_ctr.sv
// sat_ctr: combinational saturating up/down counter next-state.
//   ctr_in  - current counter value.
//   inc     - 1 = count up, 0 = count down.
//   ctr_out - next value, clamped at 0 and all-ones.
module sat_ctr #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr_in,
    input  logic             inc,
    output logic [CTR_W-1:0] ctr_out
);

    always_comb begin
        ctr_out = ctr_in;
        if (inc) begin
            if (ctr_in != '1) ctr_out = ctr_in + CTR_W'(1);
        end else begin
            if (ctr_in != '0) ctr_out = ctr_in - CTR_W'(1);
        end
    end

endmodule

// File: rtl/branch_btb.sv
// branch_btb: direct-mapped branch target buffer with per-entry direction
// counters, registered mispredict/redirect and a mispredict perf counter.
//   clk, rst            - clock, synchronous active-high reset.
//   stall               - freezes all state for the cycle.
//   flush               - drops this cycle's lookup result.
//   lookup_*            - fetch request; pred_* returned one cycle later.
//   upd_*               - resolved branch/jump from execute; trains table.
//   mispredict/redirect_pc - registered outcome check of the update.
//   mispred_cnt         - saturating count of mispredicts.
// Build option: BTB_BYPASS_EN forwards a same-cycle, same-index table write
// into the lookup result; without it the lookup reads the old entry.
module branch_btb
    import branch_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             lookup_valid,
    input  logic [31:0]      lookup_pc,
    output logic             pred_valid,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_is_jmp,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_pred_taken,
    input  logic [31:0]      upd_pred_target,
    output logic             mispredict,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_ST = '1;
    localparam logic [CTR_W-1:0] CTR_WT = CTR_W'(1) << (CTR_W - 1);

    btb_entry_t table_q [ENTRIES];

    // ---------------- update path ----------------
    logic [IDX_W-1:0] u_idx;
    logic [XLEN-1:0]  u_tag;
    btb_entry_t       u_rd;
    logic             u_hit;
    logic             u_do;
    logic [CTR_W-1:0] u_ctr_nxt;
    logic             wr_en;
    btb_entry_t       wr_entry;
    logic             u_mis;

    assign u_idx = IDX_W'(pc_idx(upd_pc, IDX_W));
    assign u_tag = pc_tag(upd_pc, IDX_W);
    assign u_rd  = table_q[u_idx];
    assign u_hit = u_rd.valid && (u_rd.tag == u_tag);
    assign u_do  = upd_valid && !stall;

    sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
        .ctr_in  (u_rd.ctr[CTR_W-1:0]),
        .inc     (upd_taken),
        .ctr_out (u_ctr_nxt)
    );

    always_comb begin
        wr_en    = 1'b0;
        wr_entry = u_rd;
        if (u_do) begin
            if (u_hit) begin
                wr_en = 1'b1;
                if (upd_is_jmp) begin
                    wr_entry.ctr    = CTR_W_MAX'(CTR_ST);
                    wr_entry.target = upd_target;
                end else begin
                    wr_entry.ctr = CTR_W_MAX'(u_ctr_nxt);
                    // Not-taken outcomes keep the last known target.
                    if (upd_taken) wr_entry.target = upd_target;
                end
            end else if (upd_taken) begin
                // Allocation simply replaces whatever held this index.
                wr_en           = 1'b1;
                wr_entry.valid  = 1'b1;
                wr_entry.tag    = u_tag;
                wr_entry.target = upd_target;
                wr_entry.ctr    = CTR_W_MAX'(upd_is_jmp ? CTR_ST : CTR_WT);
            end
        end
    end

    assign u_mis = (upd_taken != upd_pred_taken) ||
                   (upd_taken && (upd_target != upd_pred_target));

    // The table is flops so reset can clear every valid bit at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) table_q[i].valid <= 1'b0;
        end else if (wr_en) begin
            table_q[u_idx] <= wr_entry;
        end
    end

    // ---------------- lookup path ----------------
    logic [IDX_W-1:0] l_idx;
    logic [XLEN-1:0]  l_tag;
    btb_entry_t       l_rd;
    logic             l_hit;
    logic             l_taken;
    logic [31:0]      l_target;

    assign l_idx = IDX_W'(pc_idx(lookup_pc, IDX_W));
    assign l_tag = pc_tag(lookup_pc, IDX_W);

    always_comb begin
        l_rd = table_q[l_idx];
`ifdef BTB_BYPASS_EN
        if (wr_en && (u_idx == l_idx)) l_rd = wr_entry;
`endif
    end

    assign l_hit    = l_rd.valid && (l_rd.tag == l_tag);
    // Upper ctr bits are stored as zero, so shifting tests the CTR_W MSB.
    assign l_taken  = l_hit && ((l_rd.ctr >> (CTR_W - 1)) != '0);
    assign l_target = l_taken ? l_rd.target : lookup_pc + 32'd4;

    // ---------------- registered outputs ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid  <= 1'b0;
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
            mispredict  <= 1'b0;
            redirect_pc <= '0;
            mispred_cnt <= '0;
        end else if (!stall) begin
            pred_valid <= lookup_valid && !flush;
            if (lookup_valid && !flush) begin
                pred_hit    <= l_hit;
                pred_taken  <= l_taken;
                pred_target <= l_target;
            end
            mispredict <= upd_valid && u_mis;
            if (upd_valid)
                redirect_pc <= upd_taken ? upd_target : upd_pc + 32'd4;
            if (upd_valid && u_mis && (mispred_cnt != '1))
                mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end

endmodule
